// File: rtl/uvmt_cv32e40s_pma_lookup_sequencer.sv
// uvmt_cv32e40s_pma_lookup_sequencer
// Shares one combinational PMA model between the instruction-fetch requester
// and the data (LSU) requester. Word-crossing misaligned data accesses become
// two word-granular lookups. One combined verdict is returned per request.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_req_*                    instruction lookup request (valid/ready, addr)
//   d_req_*                    data lookup request (valid/ready, addr, size, load)
//   lu_*  (out)                lookup drive towards the PMA model
//   lu_allow, lu_main (in)     same-cycle PMA model verdict
//   rsp_* (valid/ready)        combined verdict: src, allow, main, split, fault half
module uvmt_cv32e40s_pma_lookup_sequencer #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [31:0]           i_req_addr,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [31:0]           d_req_addr,
  input  logic [1:0]            d_req_size,
  input  logic                  d_req_load,
  output logic                  lu_valid,
  output logic [31:0]           lu_addr,
  output logic                  lu_is_instr,
  output logic                  lu_load,
  output logic                  lu_misaligned,
  input  logic                  lu_allow,
  input  logic                  lu_main,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_src,
  output logic                  rsp_allow,
  output logic                  rsp_main,
  output logic                  rsp_split,
  output logic                  rsp_fault_half
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, LU0, LU1, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 1 = data
  logic                cap_data_q, cap_data_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic                cap_split_q, cap_split_d;
  logic                h0_main_q, h0_main_d;
  logic                lu_valid_q, lu_valid_d;
  logic [ADDR_W-1:0]   lu_addr_q, lu_addr_d;
  logic                lu_is_instr_q, lu_is_instr_d;
  logic                lu_load_q, lu_load_d;
  logic                lu_mis_q, lu_mis_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_src_q, rsp_src_d;
  logic                rsp_allow_q, rsp_allow_d;
  logic                rsp_main_q, rsp_main_d;
  logic                rsp_split_q, rsp_split_d;
  logic                rsp_fh_q, rsp_fh_d;

  logic                gnt_data_c;
  logic                gnt_instr_c;
  logic [2:0]          d_bytes_c;
  logic                d_split_c;
  logic                d_mis_c;
  logic [ADDR_W-1:0]   lu1_addr_c;

  // Arbitration: on contention round-robin flips away from the last winner
  always_comb begin
    gnt_data_c  = d_req_valid && (!i_req_valid || !RR_ENABLE || !last_grant_q);
    gnt_instr_c = i_req_valid && !gnt_data_c;
  end

  assign i_req_ready = !rst && (state_q == IDLE) && gnt_instr_c;
  assign d_req_ready = !rst && (state_q == IDLE) && gnt_data_c;

  // Data access geometry: size encoding 3 behaves as word
  always_comb begin
    case (d_req_size)
      2'd0:    d_bytes_c = 3'd1;
      2'd1:    d_bytes_c = 3'd2;
      default: d_bytes_c = 3'd4;
    endcase
    d_split_c = (3'({1'b0, d_req_addr[1:0]}) + d_bytes_c) > 3'd4;
    d_mis_c   = ((d_req_size == 2'd1) && d_req_addr[0]) ||
                (d_req_size[1] && (d_req_addr[1:0] != 2'b00));
  end

  // Second half starts at the next word; wraps at the top of the address space
  assign lu1_addr_c = {cap_addr_q[ADDR_W-1:2] + WORD_W'(1), 2'b00};

  // Next-state and registered output computation
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cap_data_d    = cap_data_q;
    cap_addr_d    = cap_addr_q;
    cap_split_d   = cap_split_q;
    h0_main_d     = h0_main_q;
    lu_valid_d    = lu_valid_q;
    lu_addr_d     = lu_addr_q;
    lu_is_instr_d = lu_is_instr_q;
    lu_load_d     = lu_load_q;
    lu_mis_d      = lu_mis_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_src_d     = rsp_src_q;
    rsp_allow_d   = rsp_allow_q;
    rsp_main_d    = rsp_main_q;
    rsp_split_d   = rsp_split_q;
    rsp_fh_d      = rsp_fh_q;

    case (state_q)
      IDLE: begin
        if (gnt_data_c || gnt_instr_c) begin
          state_d       = LU0;
          last_grant_d  = gnt_data_c;
          cap_data_d    = gnt_data_c;
          cap_addr_d    = gnt_data_c ? d_req_addr : i_req_addr;
          cap_split_d   = gnt_data_c && d_split_c;
          lu_valid_d    = 1'b1;
          lu_addr_d     = gnt_data_c ? d_req_addr : i_req_addr;
          lu_is_instr_d = !gnt_data_c;
          lu_load_d     = gnt_data_c && d_req_load;
          lu_mis_d      = gnt_data_c && d_mis_c;
        end
      end
      LU0: begin
        if (cap_split_q && lu_allow) begin
          state_d   = LU1;
          h0_main_d = lu_main;
          lu_addr_d = lu1_addr_c;
        end else begin
          // Unsplit, or half 0 faulted: half 1 is never looked up
          state_d       = RESP;
          lu_valid_d    = 1'b0;
          lu_addr_d     = '0;
          lu_is_instr_d = 1'b0;
          lu_load_d     = 1'b0;
          lu_mis_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_src_d     = cap_data_q;
          rsp_allow_d   = lu_allow;
          rsp_main_d    = lu_main;
          rsp_split_d   = cap_split_q;
          rsp_fh_d      = 1'b0;
        end
      end
      LU1: begin
        state_d       = RESP;
        lu_valid_d    = 1'b0;
        lu_addr_d     = '0;
        lu_is_instr_d = 1'b0;
        lu_load_d     = 1'b0;
        lu_mis_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_src_d     = cap_data_q;
        rsp_allow_d   = lu_allow;
        rsp_main_d    = h0_main_q && lu_main;
        rsp_split_d   = 1'b1;
        rsp_fh_d      = !lu_allow;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_src_d   = 1'b0;
          rsp_allow_d = 1'b0;
          rsp_main_d  = 1'b0;
          rsp_split_d = 1'b0;
          rsp_fh_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      cap_data_q    <= 1'b0;
      cap_addr_q    <= '0;
      cap_split_q   <= 1'b0;
      h0_main_q     <= 1'b0;
      lu_valid_q    <= 1'b0;
      lu_addr_q     <= '0;
      lu_is_instr_q <= 1'b0;
      lu_load_q     <= 1'b0;
      lu_mis_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_src_q     <= 1'b0;
      rsp_allow_q   <= 1'b0;
      rsp_main_q    <= 1'b0;
      rsp_split_q   <= 1'b0;
      rsp_fh_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cap_data_q    <= cap_data_d;
      cap_addr_q    <= cap_addr_d;
      cap_split_q   <= cap_split_d;
      h0_main_q     <= h0_main_d;
      lu_valid_q    <= lu_valid_d;
      lu_addr_q     <= lu_addr_d;
      lu_is_instr_q <= lu_is_instr_d;
      lu_load_q     <= lu_load_d;
      lu_mis_q      <= lu_mis_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_src_q     <= rsp_src_d;
      rsp_allow_q   <= rsp_allow_d;
      rsp_main_q    <= rsp_main_d;
      rsp_split_q   <= rsp_split_d;
      rsp_fh_q      <= rsp_fh_d;
    end
  end

  assign lu_valid       = lu_valid_q;
  assign lu_addr        = lu_addr_q;
  assign lu_is_instr    = lu_is_instr_q;
  assign lu_load        = lu_load_q;
  assign lu_misaligned  = lu_mis_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_src        = rsp_src_q;
  assign rsp_allow      = rsp_allow_q;
  assign rsp_main       = rsp_main_q;
  assign rsp_split      = rsp_split_q;
  assign rsp_fault_half = rsp_fh_q;

endmodule

// File: tb/tb_uvmt_cv32e40s_pma_lookup_sequencer.sv
// Testbench for uvmt_cv32e40s_pma_lookup_sequencer: directed vector table,
// arbitration and reset corner sequences, then randomized requests checked
// against a request-level reference model. Instance a uses round-robin,
// instance b has the data requester always winning.
module tb_uvmt_cv32e40s_pma_lookup_sequencer;

  localparam logic [29:0] NONE_W = 30'h0ABC_DEF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, d_req_valid, d_req_load, rsp_ready;
  logic [31:0] i_req_addr, d_req_addr;
  logic [1:0]  d_req_size;

  logic        a_i_ready, a_d_ready, a_lu_valid, a_lu_is_instr, a_lu_load, a_lu_mis;
  logic [31:0] a_lu_addr;
  logic        a_lu_allow, a_lu_main;
  logic        a_rsp_valid, a_rsp_src, a_rsp_allow, a_rsp_main, a_rsp_split, a_rsp_fh;
  logic        b_i_ready, b_d_ready, b_lu_valid, b_lu_is_instr, b_lu_load, b_lu_mis;
  logic [31:0] b_lu_addr;
  logic        b_lu_allow, b_lu_main;
  logic        b_rsp_valid, b_rsp_src, b_rsp_allow, b_rsp_main, b_rsp_split, b_rsp_fh;

  logic [29:0] deny_w, nonmain_w;
  bit          rand_mode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // PMA environment: word-granular deny / non-main, plus a pattern in random mode
  always_comb begin
    a_lu_allow = (a_lu_addr[31:2] != deny_w) && (!rand_mode || (a_lu_addr[31:2] % 3) != 0);
    a_lu_main  = (a_lu_addr[31:2] != nonmain_w) && (!rand_mode || (a_lu_addr[31:2] % 5) != 0);
    b_lu_allow = (b_lu_addr[31:2] != deny_w) && (!rand_mode || (b_lu_addr[31:2] % 3) != 0);
    b_lu_main  = (b_lu_addr[31:2] != nonmain_w) && (!rand_mode || (b_lu_addr[31:2] % 5) != 0);
  end

  uvmt_cv32e40s_pma_lookup_sequencer #(.RR_ENABLE(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(a_i_ready), .i_req_addr(i_req_addr),
    .d_req_valid(d_req_valid), .d_req_ready(a_d_ready), .d_req_addr(d_req_addr),
    .d_req_size(d_req_size), .d_req_load(d_req_load),
    .lu_valid(a_lu_valid), .lu_addr(a_lu_addr), .lu_is_instr(a_lu_is_instr),
    .lu_load(a_lu_load), .lu_misaligned(a_lu_mis), .lu_allow(a_lu_allow), .lu_main(a_lu_main),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_src(a_rsp_src),
    .rsp_allow(a_rsp_allow), .rsp_main(a_rsp_main), .rsp_split(a_rsp_split),
    .rsp_fault_half(a_rsp_fh)
  );

  uvmt_cv32e40s_pma_lookup_sequencer #(.RR_ENABLE(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(b_i_ready), .i_req_addr(i_req_addr),
    .d_req_valid(d_req_valid), .d_req_ready(b_d_ready), .d_req_addr(d_req_addr),
    .d_req_size(d_req_size), .d_req_load(d_req_load),
    .lu_valid(b_lu_valid), .lu_addr(b_lu_addr), .lu_is_instr(b_lu_is_instr),
    .lu_load(b_lu_load), .lu_misaligned(b_lu_mis), .lu_allow(b_lu_allow), .lu_main(b_lu_main),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_src(b_rsp_src),
    .rsp_allow(b_rsp_allow), .rsp_main(b_rsp_main), .rsp_split(b_rsp_split),
    .rsp_fault_half(b_rsp_fh)
  );

  typedef struct {
    bit          data;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          load;
    logic [29:0] deny;
    logic [29:0] nonmain;
    bit          mis;
    bit          split;
    bit          lu1;
    logic [31:0] addr1;
    bit          allow;
    bit          main;
    bit          fh;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit env_allow(input logic [31:0] a);
    return (a[31:2] != deny_w) && (!rand_mode || (a[31:2] % 3) != 0);
  endfunction

  function automatic bit env_main(input logic [31:0] a);
    return (a[31:2] != nonmain_w) && (!rand_mode || (a[31:2] % 5) != 0);
  endfunction

  // Request-level reference: which words get looked up and how verdicts combine
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   bytes;
    bit   a0, m0, a1, m1;
    bytes   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    r.split = v.data && ((int'(v.addr[1:0]) + bytes) > 4);
    r.mis   = v.data && ((v.addr % 32'(bytes)) != 0);
    r.addr1 = (v.addr & 32'hFFFF_FFFC) + 32'd4;
    a0 = env_allow(v.addr);
    m0 = env_main(v.addr);
    r.fh  = 1'b0;
    r.lu1 = 1'b0;
    if (!a0) begin
      r.allow = 1'b0;
      r.main  = m0;
    end else if (r.split) begin
      a1 = env_allow(r.addr1);
      m1 = env_main(r.addr1);
      r.lu1   = 1'b1;
      r.allow = a1;
      r.main  = m0 && m1;
      r.fh    = !a1;
    end else begin
      r.allow = 1'b1;
      r.main  = m0;
    end
    return r;
  endfunction

  task automatic chk_rsp(input vec_t e);
    chk("rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("rsp_src", 32'(a_rsp_src), 32'(e.data));
    chk("rsp_allow", 32'(a_rsp_allow), 32'(e.allow));
    chk("rsp_main", 32'(a_rsp_main), 32'(e.main));
    chk("rsp_split", 32'(a_rsp_split), 32'(e.split));
    chk("rsp_fault_half", 32'(a_rsp_fh), 32'(e.fh));
  endtask

  task automatic chk_lu(input vec_t e, input logic [31:0] addr);
    chk("lu_valid", 32'(a_lu_valid), 32'd1);
    chk("lu_addr", a_lu_addr, addr);
    chk("lu_is_instr", 32'(a_lu_is_instr), 32'(!e.data));
    chk("lu_load", 32'(a_lu_load), 32'(e.data && e.load));
    chk("lu_misaligned", 32'(a_lu_mis), 32'(e.mis));
    chk("rsp_valid_busy", 32'(a_rsp_valid), 32'd0);
  endtask

  // One request from idle through to the response handshake
  task automatic run_req(input vec_t e, input int hold);
    i_req_valid = !e.data;
    d_req_valid = e.data;
    i_req_addr  = e.addr;
    d_req_addr  = e.addr;
    d_req_size  = e.size;
    d_req_load  = e.load;
    rsp_ready   = 1'b1;
    #1;
    chk("accept_ready", 32'(e.data ? a_d_ready : a_i_ready), 32'd1);
    chk("other_ready", 32'(e.data ? a_i_ready : a_d_ready), 32'd0);
    tick();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    i_req_addr  = $urandom;
    d_req_addr  = $urandom;
    d_req_size  = 2'($urandom);
    d_req_load  = 1'($urandom);
    chk_lu(e, e.addr);
    if (e.lu1) begin
      tick();
      chk_lu(e, e.addr1);
    end
    tick();
    chk_rsp(e);
    chk("lu_valid_resp", 32'(a_lu_valid), 32'd0);
    if (hold > 0) begin
      rsp_ready   = 1'b0;
      i_req_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        #1;
        chk("no_ready_busy", 32'(a_i_ready), 32'd0);
        tick();
        chk_rsp(e);
      end
      i_req_valid = 1'b0;
      rsp_ready   = 1'b1;
    end
    tick();
    chk("rsp_done", 32'(a_rsp_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lu_valid"}, 32'(a_lu_valid), 32'd0);
    chk({tag, "_lu_addr"}, a_lu_addr, 32'd0);
    chk({tag, "_lu_flags"}, 32'({a_lu_is_instr, a_lu_load, a_lu_mis}), 32'd0);
    chk({tag, "_rsp"}, 32'({a_rsp_valid, a_rsp_src, a_rsp_allow, a_rsp_main, a_rsp_split, a_rsp_fh}), 32'd0);
    chk({tag, "_ready"}, 32'({a_i_ready, a_d_ready}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) tick();
    chk_all_zero("in_reset");
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");
  endtask

  vec_t tbl[9];
  vec_t e;

  initial begin
    i_req_addr = '0; d_req_addr = '0; d_req_size = '0; d_req_load = 1'b0;
    deny_w = NONE_W; nonmain_w = NONE_W; rand_mode = 1'b0;
    //          data  addr            sz    ld    deny     nonmain  mis  spl  lu1  addr1           allow main fh
    tbl[0] = '{1'b0, 32'h0000_1000, 2'd0, 1'b0, NONE_W,  NONE_W,  1'b0,1'b0,1'b0,32'h0,          1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_2002, 2'd2, 1'b1, NONE_W,  NONE_W,  1'b1,1'b1,1'b1,32'h0000_2004,  1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_2002, 2'd2, 1'b1, 30'h801, 30'h801, 1'b1,1'b1,1'b1,32'h0000_2004,  1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, NONE_W,  NONE_W,  1'b1,1'b1,1'b1,32'h0000_0000,  1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_3003, 2'd0, 1'b1, NONE_W,  NONE_W,  1'b0,1'b0,1'b0,32'h0,          1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_2002, 2'd2, 1'b0, 30'h800, NONE_W,  1'b1,1'b1,1'b0,32'h0,          1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_4002, 2'd1, 1'b1, NONE_W,  30'h1000,1'b0,1'b0,1'b0,32'h0,          1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'h0000_5001, 2'd3, 1'b0, NONE_W,  NONE_W,  1'b1,1'b1,1'b1,32'h0000_5004,  1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 32'h0000_7FFE, 2'd2, 1'b1, 30'h1FFF,NONE_W,  1'b0,1'b0,1'b0,32'h0,          1'b0, 1'b1, 1'b0};

    do_reset();

    // Directed vectors; vector 1 holds the response off for five cycles
    for (int i = 0; i < 9; i++) begin
      deny_w    = tbl[i].deny;
      nonmain_w = tbl[i].nonmain;
      run_req(tbl[i], (i == 1) ? 5 : (i % 3));
    end
    deny_w = NONE_W;
    nonmain_w = NONE_W;

    // Contention from reset: a alternates starting with instr, b always data
    do_reset();
    begin
      int ga = 0, gb = 0;
      bit exp_d = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 32'h0000_0100;
      d_req_valid = 1'b1; d_req_addr = 32'h0000_0200; d_req_size = 2'd2; d_req_load = 1'b1;
      for (int c = 0; c < 12; c++) begin
        #1;
        if (a_i_ready || a_d_ready) begin
          chk("rr_one_hot", 32'({a_i_ready, a_d_ready}), exp_d ? 32'd1 : 32'd2);
          exp_d = !exp_d;
          ga++;
        end
        if (b_i_ready || b_d_ready) begin
          chk("fixed_data_wins", 32'({b_i_ready, b_d_ready}), 32'd1);
          gb++;
        end
        tick();
      end
      chk("rr_grant_count", 32'(ga), 32'd4);
      chk("fixed_grant_count", 32'(gb), 32'd4);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      repeat (3) tick();
    end

    // Reset pulsed during LU1 drops the request and restores last_grant
    do_reset();
    e = tbl[1];
    i_req_valid = 1'b0; d_req_valid = 1'b1;
    d_req_addr = e.addr; d_req_size = e.size; d_req_load = e.load;
    #1;
    chk("mid_rst_accept", 32'(a_d_ready), 32'd1);
    tick();
    d_req_valid = 1'b0;
    chk_lu(e, e.addr);
    tick();
    chk_lu(e, e.addr1);
    rst = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    tick();
    chk_all_zero("mid_rst_after");
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0300;
    d_req_valid = 1'b1;
    #1;
    chk("rst_grant_instr", 32'({a_i_ready, a_d_ready}), 32'd2);
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (4) tick();
    chk("mid_rst_idle", 32'(a_rsp_valid), 32'd0);

    // Randomized requests against the reference model
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      vec_t v;
      v.data    = 1'($urandom);
      v.addr    = ($urandom % 8 == 0) ? (32'hFFFF_FFFC | 32'($urandom % 4)) : $urandom;
      v.size    = 2'($urandom);
      v.load    = 1'($urandom);
      v.deny    = NONE_W;
      v.nonmain = NONE_W;
      v.mis = 1'b0; v.split = 1'b0; v.lu1 = 1'b0; v.addr1 = '0;
      v.allow = 1'b0; v.main = 1'b0; v.fh = 1'b0;
      run_req(model(v), int'($urandom % 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
